data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the per-thread LSU data-memory handshake of a compute core. It accepts read/write requests from up to NUM_CONSUMERS LSU channels, serializes them through a round-robin arbiter, and services them from an internal Q1.15 data store with fixed latency. A host preload port initializes memory before kernel launch. It sits between a core's data-memory port arrays and the backing store.

## Interface

Parameters:
- NUM_CONSUMERS, 4, number of LSU request channels (threads per block).
- ADDR_BITS, 12, request address width.
- DATA_BITS, 16, data word width (Q1.15).
- DEPTH, 4096, words of storage; power of two, ≤ 2^ADDR_BITS.
- LATENCY, 2, cycles from grant to ready pulse; ≥ 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- read_valid  in  [NUM_CONSUMERS]  per-consumer read request, held until read_ready.
- read_address  in  ADDR_BITS x NUM_CONSUMERS (unpacked)  read address.
- read_ready  out  [NUM_CONSUMERS]  one-cycle read completion pulse.
- read_data  out  DATA_BITS x NUM_CONSUMERS (unpacked)  read result; valid with read_ready, held until that consumer's next read completes.
- write_valid  in  [NUM_CONSUMERS]  per-consumer write request, held until write_ready.
- write_address  in  ADDR_BITS x NUM_CONSUMERS  write address.
- write_data  in  DATA_BITS x NUM_CONSUMERS  write data.
- write_ready  out  [NUM_CONSUMERS]  one-cycle write completion pulse.
- host_write_en  in  1  host preload strobe.
- host_address  in  ADDR_BITS  host preload address.
- host_data  in  DATA_BITS  host preload data.
- busy  out  1  high while a transaction is outstanding (state ≠ IDLE).
- oob_error  out  1  sticky out-of-range flag (see Configuration).

## Operation

- States: IDLE, WAIT, RESP.
- IDLE: candidates are consumers with read_valid or write_valid high. Scan starts at rr_ptr, ascending with wrap. First candidate is granted at the clock edge. No candidate means stay in IDLE.
- Within one consumer, write beats read. A consumer holding both gets its write served. Its read stays pending for a later arbitration.
- At grant: writes commit to memory, reads capture memory into a holding register, rr_ptr becomes (granted+1) mod NUM_CONSUMERS, and the latched grant index and op are stored.
- After grant: go to WAIT with counter LATENCY-1. If LATENCY=1, go directly to RESP.
- WAIT: counter decrements each cycle. Go to RESP when it reaches 0.
- RESP: pulse read_ready or write_ready of the granted consumer for exactly one cycle. On a read, load read_data[granted] from the holding register. Return to IDLE.
- Only one transaction is outstanding, so there is no grant in WAIT or RESP. LSUs drop valid at the edge ending the RESP cycle, so a served request is never re-granted.
- Host write: commits unconditionally at the edge where host_write_en=1, in any state.
  - Host write and consumer write grant at the same edge and same address: host data wins.
  - Host write and consumer read grant at the same edge and same address: the read returns the old value.
- Memory contents are not cleared by reset.

## Timing

- Request first visible in IDLE cycle t: grant at the edge ending t, ready pulse high in cycle t+LATENCY.
- Back-to-back throughput: one transaction per LATENCY+1 cycles.
- Reset values: read_ready=0, write_ready=0, read_data[*]=0, busy=0, oob_error=0, state=IDLE, rr_ptr=0.
- Reset during WAIT or RESP:
  - The transaction is abandoned and no ready pulse is issued.
  - A write already granted stays committed.
  - busy=0 in the cycle after reset.
- busy rises in cycle t+1 and falls in cycle t+LATENCY+1.

## Configuration

- DATA_MEM_RESPONDER_BOUNDS_CHECK_EN defined:
  - Any address ≥ DEPTH is out of range.
  - An out-of-range read returns 0; an out-of-range write is dropped. Both still complete with a ready pulse.
  - oob_error is set at grant and cleared only by reset.
  - An out-of-range host write is dropped but does not set oob_error.
- Macro undefined: the low $clog2(DEPTH) address bits index memory (aliasing), and oob_error is tied 0.

## Test plan

- Host preload addr 5 = 0x4000; LATENCY=2; read_valid[0] with addr 5 rises cycle t → read_ready[0] high only in cycle t+2, read_data[0]=0x4000, busy high cycles t+1..t+2.
- All four consumers raise read_valid in the same cycle → grants in order 0,1,2,3; ready pulses spaced 3 cycles apart. Then, after granting 1, consumers 0 and 2 request together → 2 served before 0.
- Consumer 1 writes 0x8001 to addr 10 → write_ready[1] pulse; then consumer 3 reads addr 10 → read_data[3]=0x8001.
- Consumer 2 holds read and write valid together (write 0x1234 to addr 7, read addr 7) → write_ready[2] first; the read is served next and returns 0x1234.
- Reset asserted during WAIT of a read → no read_ready pulse; busy=0 and rr_ptr=0 the next cycle; the re-presented request completes normally.
- DEPTH=1024, read addr 0x400 with preload addr 0 = 0x7FFF → with the macro, data 0 and oob_error=1; without the macro, data 0x7FFF and oob_error=0.

Source files
------------

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Per-consumer LSU data-memory handshake bundle. The LSU side
//               uses the master modport and the responder uses slave.
//   read_valid    [NUM_CONSUMERS]          read request, held until read_ready
//   read_address  ADDR_BITS x NUM_CONSUMERS read address
//   read_ready    [NUM_CONSUMERS]          one-cycle read completion pulse
//   read_data     DATA_BITS x NUM_CONSUMERS read result, held until next read
//   write_valid   [NUM_CONSUMERS]          write request, held until write_ready
//   write_address ADDR_BITS x NUM_CONSUMERS write address
//   write_data    DATA_BITS x NUM_CONSUMERS write data
//   write_ready   [NUM_CONSUMERS]          one-cycle write completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 12,
  parameter int DATA_BITS     = 16
);
  logic [NUM_CONSUMERS-1:0] read_valid;
  logic [ADDR_BITS-1:0]     read_address  [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] read_ready;
  logic [DATA_BITS-1:0]     read_data     [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] write_valid;
  logic [ADDR_BITS-1:0]     write_address [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     write_data    [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] write_ready;

  modport master (
    output read_valid, read_address, write_valid, write_address, write_data,
    input  read_ready, read_data, write_ready
  );

  modport slave (
    input  read_valid, read_address, write_valid, write_address, write_data,
    output read_ready, read_data, write_ready
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Memory-side responder for per-thread LSU data-memory requests.
//               Requests are serialized by a round-robin arbiter (write wins
//               over read within a consumer) and serviced from an internal
//               Q1.15 store with a fixed grant-to-ready latency. A host port
//               preloads memory in any state.
// Ports       :
//   clk           in   clock
//   reset         in   synchronous, active-high reset
//   bus           slave modport of data_mem_responder_if (LSU handshakes)
//   host_write_en in   host preload strobe
//   host_address  in   host preload address
//   host_data     in   host preload data
//   busy          out  a transaction is outstanding
//   oob_error     out  sticky out-of-range flag
// Options     : DATA_MEM_RESPONDER_BOUNDS_CHECK_EN - addresses >= DEPTH are
//               rejected (read 0 / write dropped) and flagged on oob_error.
//               When undefined, the low address bits index memory (aliasing).
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 12,
  parameter int DATA_BITS     = 16,
  parameter int DEPTH         = 4096,
  parameter int LATENCY       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus,
  input  logic                  host_write_en,
  input  logic [ADDR_BITS-1:0]  host_address,
  input  logic [DATA_BITS-1:0]  host_data,
  output logic                  busy,
  output logic                  oob_error
);

  localparam int IDX_BITS = $clog2(DEPTH);
  localparam int PTR_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [PTR_BITS-1:0]  rr_ptr_q,  rr_ptr_d;
  logic [PTR_BITS-1:0]  gnt_idx_q, gnt_idx_d;
  logic                 gnt_wr_q,  gnt_wr_d;
  logic [CNT_BITS-1:0]  cnt_q,     cnt_d;
  logic [DATA_BITS-1:0] rd_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] rd_data_d [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] hold_q;
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic [PTR_BITS-1:0]      cand_idx;
  logic                     cand_found;
  logic                     grant;
  logic                     g_wr;
  logic [ADDR_BITS-1:0]     g_addr;
  logic [DATA_BITS-1:0]     g_wdata;
  logic [IDX_BITS-1:0]      g_idx;
  logic                     g_in_range;
  logic [IDX_BITS-1:0]      host_idx;
  logic                     host_in_range;
  logic [NUM_CONSUMERS-1:0] rd_pulse;
  logic [NUM_CONSUMERS-1:0] wr_pulse;

  // --------------------------------------------------------------------------
  // Round-robin scan: first requesting consumer at or after rr_ptr, with wrap.
  // --------------------------------------------------------------------------
  always_comb begin : arbiter
    int                  j;
    logic [PTR_BITS-1:0] jj;
    j          = 0;
    jj         = '0;
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_CONSUMERS) j = j - NUM_CONSUMERS;
      jj = PTR_BITS'(j);
      if (!cand_found && (bus.read_valid[jj] || bus.write_valid[jj])) begin
        cand_found = 1'b1;
        cand_idx   = jj;
      end
    end
  end

  // A consumer holding both requests has its write served first; the read
  // stays pending and competes again in a later arbitration.
  assign g_wr    = bus.write_valid[cand_idx];
  assign g_addr  = g_wr ? bus.write_address[cand_idx] : bus.read_address[cand_idx];
  assign g_wdata = bus.write_data[cand_idx];
  assign g_idx   = g_addr[IDX_BITS-1:0];
  assign host_idx = host_address[IDX_BITS-1:0];

  // Reset blocks a grant so nothing is committed on a reset edge.
  assign grant = (state_q == ST_IDLE) && cand_found && !reset;

`ifdef DATA_MEM_RESPONDER_BOUNDS_CHECK_EN
  localparam logic [ADDR_BITS:0] DEPTH_LIM = (ADDR_BITS+1)'(DEPTH);
  assign g_in_range    = ({1'b0, g_addr} < DEPTH_LIM);
  assign host_in_range = ({1'b0, host_address} < DEPTH_LIM);
`else
  assign g_in_range    = 1'b1;
  assign host_in_range = 1'b1;
  // Upper address bits are ignored when aliasing into a smaller store.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{g_addr, host_address};
`endif

  // --------------------------------------------------------------------------
  // Storage. The host write is placed last so it overrides a consumer write
  // to the same word at the same edge; a read granted at that edge samples
  // the pre-edge contents into hold_q.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (grant && !g_wr) begin
      hold_q <= g_in_range ? mem_q[g_idx] : '0;
    end
    if (grant && g_wr && g_in_range) begin
      mem_q[g_idx] <= g_wdata;
    end
    if (host_write_en && host_in_range) begin
      mem_q[host_idx] <= host_data;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      gnt_wr_q  <= 1'b0;
      cnt_q     <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) rd_data_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_wr_q  <= gnt_wr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and response pulses
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_wr_d  = gnt_wr_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    rd_pulse  = '0;
    wr_pulse  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          gnt_idx_d = cand_idx;
          gnt_wr_d  = g_wr;
          rr_ptr_d  = (cand_idx == PTR_BITS'(NUM_CONSUMERS - 1)) ? '0 : cand_idx + 1'b1;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_BITS'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        // Leaving on the edge where the count reaches zero.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_BITS'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (gnt_wr_q) begin
          wr_pulse[gnt_idx_q] = 1'b1;
        end else begin
          rd_pulse[gnt_idx_q]  = 1'b1;
          rd_data_d[gnt_idx_q] = hold_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DATA_MEM_RESPONDER_BOUNDS_CHECK_EN
  logic oob_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      oob_q <= 1'b0;
    end else if (grant && !g_in_range) begin
      oob_q <= 1'b1;
    end
  end
  assign oob_error = oob_q;
`else
  assign oob_error = 1'b0;
`endif

  assign busy            = (state_q != ST_IDLE);
  assign bus.read_ready  = rd_pulse;
  assign bus.write_ready = wr_pulse;

  // During the RESP cycle the fresh result is forwarded from hold_q so it is
  // valid together with read_ready; it is registered at the end of RESP.
  for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_rdata
    assign bus.read_data[gi] =
        ((state_q == ST_RESP) && !gnt_wr_q && (gnt_idx_q == PTR_BITS'(gi)))
        ? hold_q : rd_data_q[gi];
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. A behavioural
//               model (word array, round-robin pointer, sticky flag) predicts
//               the completion order, completion cycle and read data of each
//               batch of requests; observed pulses are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int NC    = 4;
  localparam int AB    = 12;
  localparam int DB    = 16;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  typedef struct {
    int          c;
    bit          wr;
    int          cyc;
    logic [DB-1:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          host_write_en = 1'b0;
  logic [AB-1:0] host_address = '0;
  logic [DB-1:0] host_data = '0;
  logic          busy;
  logic          oob_error;
  int            cyc = 0;

  int checks = 0;
  int failures = 0;

  data_mem_responder_if #(.NUM_CONSUMERS(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  data_mem_responder #(
    .NUM_CONSUMERS(NC), .ADDR_BITS(AB), .DATA_BITS(DB), .DEPTH(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .host_write_en(host_write_en), .host_address(host_address), .host_data(host_data),
    .busy(busy), .oob_error(oob_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [DB-1:0] mem_m [DEPTH];
  int            ptr_m = 0;
  bit            oob_m = 1'b0;

  function automatic bit in_range(input logic [AB-1:0] a);
`ifdef DATA_MEM_RESPONDER_BOUNDS_CHECK_EN
    return int'(a) < DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [DB-1:0] model_read(input logic [AB-1:0] a);
    return in_range(a) ? mem_m[int'(a) % DEPTH] : '0;
  endfunction

  task automatic model_write(input logic [AB-1:0] a, input logic [DB-1:0] d);
    if (in_range(a)) mem_m[int'(a) % DEPTH] = d;
  endtask

  // ---------------- stimulus state ----------------
  bit            rq_rd [NC];
  bit            rq_wr [NC];
  logic [AB-1:0] rq_ra [NC];
  logic [AB-1:0] rq_wa [NC];
  logic [DB-1:0] rq_wd [NC];
  ev_t           exp_q [$];
  ev_t           got_q [$];

  task automatic clear_req();
    for (int c = 0; c < NC; c++) begin
      rq_rd[c] = 0; rq_wr[c] = 0; rq_ra[c] = '0; rq_wa[c] = '0; rq_wd[c] = '0;
    end
  endtask

  task automatic drop_all();
    bus.read_valid  = '0;
    bus.write_valid = '0;
  endtask

  // Requests present together in idle cycle t0; serve in round-robin order,
  // write before read per consumer, one completion every LAT+1 cycles.
  task automatic predict(input int t0);
    bit  prd [NC];
    bit  pwr [NC];
    int  t;
    int  left;
    t = t0;
    left = 0;
    for (int c = 0; c < NC; c++) begin
      prd[c] = rq_rd[c]; pwr[c] = rq_wr[c];
      left += int'(prd[c]) + int'(pwr[c]);
    end
    while (left > 0) begin
      ev_t e;
      int  sel;
      sel = -1;
      for (int k = 0; k < NC; k++) begin
        int j;
        j = (ptr_m + k) % NC;
        if (sel < 0 && (prd[j] || pwr[j])) sel = j;
      end
      e.c = sel;
      e.cyc = t + LAT;
      if (pwr[sel]) begin
        e.wr = 1'b1; e.data = '0;
        if (!in_range(rq_wa[sel])) oob_m = 1'b1;
        model_write(rq_wa[sel], rq_wd[sel]);
        pwr[sel] = 0;
      end else begin
        e.wr = 1'b0;
        if (!in_range(rq_ra[sel])) oob_m = 1'b1;
        e.data = model_read(rq_ra[sel]);
        prd[sel] = 0;
      end
      exp_q.push_back(e);
      ptr_m = (sel + 1) % NC;
      t += LAT + 1;
      left--;
    end
  endtask

  // Acts as the LSUs: records each ready pulse and drops the served valid.
  task automatic collect(input int n);
    int budget;
    int seen;
    budget = n * (LAT + 1) + 20;
    seen = 0;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      host_write_en = 1'b0;
      for (int c = 0; c < NC; c++) begin
        ev_t e;
        if (bus.read_ready[c]) begin
          e.c = c; e.wr = 1'b0; e.cyc = cyc; e.data = bus.read_data[c];
          got_q.push_back(e);
          bus.read_valid[c] = 1'b0;
          seen++;
        end
        if (bus.write_ready[c]) begin
          e.c = c; e.wr = 1'b1; e.cyc = cyc; e.data = '0;
          got_q.push_back(e);
          bus.write_valid[c] = 1'b0;
          seen++;
        end
      end
    end
  endtask

  task automatic run_batch(input bit hw, input logic [AB-1:0] ha, input logic [DB-1:0] hd);
    int n;
    n = 0;
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      n += int'(rq_rd[c]) + int'(rq_wr[c]);
      bus.read_valid[c]    = rq_rd[c];
      bus.write_valid[c]   = rq_wr[c];
      bus.read_address[c]  = rq_ra[c];
      bus.write_address[c] = rq_wa[c];
      bus.write_data[c]    = rq_wd[c];
    end
    host_write_en = hw; host_address = ha; host_data = hd;
    predict(cyc);
    if (hw && in_range(ha)) mem_m[int'(ha) % DEPTH] = hd;
    collect(n);
    drop_all();
  endtask

  task automatic host_wr(input logic [AB-1:0] a, input logic [DB-1:0] d);
    @(negedge clk);
    host_write_en = 1'b1; host_address = a; host_data = d;
    if (in_range(a)) mem_m[int'(a) % DEPTH] = d;
    @(negedge clk);
    host_write_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drop_all();
    host_write_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ptr_m = 0;
    oob_m = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drop_all();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (bus.read_ready !== '0) begin failures++; $display("FAIL reset_read_ready: got %b expected 0", bus.read_ready); end
    checks++;
    if (bus.write_ready !== '0) begin failures++; $display("FAIL reset_write_ready: got %b expected 0", bus.write_ready); end
    checks++;
    if (oob_error !== 1'b0) begin failures++; $display("FAIL reset_oob: got %b expected 0", oob_error); end
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (bus.read_data[c] !== '0) begin failures++; $display("FAIL reset_read_data[%0d]: got %h expected 0000", c, bus.read_data[c]); end
    end
    reset = 1'b0;
    ptr_m = 0;
  endtask

  task automatic test_single_read();
    host_wr(12'd5, 16'h4000);
    @(negedge clk);
    bus.read_address[0] = 12'd5;
    bus.read_valid[0]   = 1'b1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_t0: got %b expected 0", busy); end
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== (k <= LAT)) begin failures++; $display("FAIL single_busy_t%0d: got %b expected %b", k, busy, (k <= LAT)); end
      checks++;
      if (bus.read_ready !== ((k == LAT) ? 4'b0001 : 4'b0000)) begin
        failures++; $display("FAIL single_ready_t%0d: got %b expected %b", k, bus.read_ready, ((k == LAT) ? 4'b0001 : 4'b0000));
      end
      if (k == LAT) begin
        checks++;
        if (bus.read_data[0] !== 16'h4000) begin failures++; $display("FAIL single_data: got %h expected 4000", bus.read_data[0]); end
        bus.read_valid[0] = 1'b0;
      end
    end
    checks++;
    if (bus.read_data[0] !== 16'h4000) begin failures++; $display("FAIL single_data_held: got %h expected 4000", bus.read_data[0]); end
    ptr_m = 1;
  endtask

  task automatic test_arbitration();
    do_reset();
    for (int a = 100; a < 104; a++) host_wr(AB'(a), DB'($urandom));
    exp_q.delete(); got_q.delete();
    clear_req();
    for (int c = 0; c < NC; c++) begin rq_rd[c] = 1; rq_ra[c] = AB'(100 + c); end
    run_batch(0, '0, '0);
    clear_req(); rq_rd[1] = 1; rq_ra[1] = 12'd101;
    run_batch(0, '0, '0);
    clear_req(); rq_rd[0] = 1; rq_ra[0] = 12'd102; rq_rd[2] = 1; rq_ra[2] = 12'd103;
    run_batch(0, '0, '0);
    clear_req(); rq_wr[1] = 1; rq_wa[1] = 12'd10; rq_wd[1] = 16'h8001;
    run_batch(0, '0, '0);
    clear_req(); rq_rd[3] = 1; rq_ra[3] = 12'd10;
    run_batch(0, '0, '0);
    clear_req(); rq_wr[2] = 1; rq_wa[2] = 12'd7; rq_wd[2] = 16'h1234; rq_rd[2] = 1; rq_ra[2] = 12'd7;
    run_batch(0, '0, '0);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL arb_count: got %0d events expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].c !== exp_q[i].c || got_q[i].wr !== exp_q[i].wr || got_q[i].cyc !== exp_q[i].cyc || got_q[i].data !== exp_q[i].data) begin
        failures++;
        $display("FAIL arb_ev%0d: got c=%0d wr=%0d cyc=%0d data=%h expected c=%0d wr=%0d cyc=%0d data=%h", i,
                 got_q[i].c, got_q[i].wr, got_q[i].cyc, got_q[i].data, exp_q[i].c, exp_q[i].wr, exp_q[i].cyc, exp_q[i].data);
      end
    end
  endtask

  task automatic test_host_collision();
    host_wr(12'd21, 16'h5555);
    exp_q.delete(); got_q.delete();
    clear_req(); rq_wr[0] = 1; rq_wa[0] = 12'd20; rq_wd[0] = 16'hAAAA;
    run_batch(1, 12'd20, 16'h2222);
    clear_req(); rq_rd[1] = 1; rq_ra[1] = 12'd21;
    run_batch(1, 12'd21, 16'h3333);
    clear_req(); rq_rd[2] = 1; rq_ra[2] = 12'd20; rq_rd[3] = 1; rq_ra[3] = 12'd21;
    run_batch(0, '0, '0);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL host_count: got %0d events expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].c !== exp_q[i].c || got_q[i].wr !== exp_q[i].wr || got_q[i].cyc !== exp_q[i].cyc || got_q[i].data !== exp_q[i].data) begin
        failures++;
        $display("FAIL host_ev%0d: got c=%0d wr=%0d cyc=%0d data=%h expected c=%0d wr=%0d cyc=%0d data=%h", i,
                 got_q[i].c, got_q[i].wr, got_q[i].cyc, got_q[i].data, exp_q[i].c, exp_q[i].wr, exp_q[i].cyc, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    bus.read_address[1] = 12'd101;
    bus.read_valid[1]   = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_wait: got %b expected 1", busy); end
    reset = 1'b1;
    drop_all();
    @(negedge clk);
    checks++;
    if (bus.read_ready !== '0) begin failures++; $display("FAIL rstmid_no_pulse: got %b expected 0000", bus.read_ready); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy_after: got %b expected 0", busy); end
    reset = 1'b0;
    ptr_m = 0;
    oob_m = 1'b0;
    // Pointer back at 0 means consumer 1 is served before consumer 3.
    exp_q.delete(); got_q.delete();
    clear_req(); rq_rd[1] = 1; rq_ra[1] = 12'd101; rq_rd[3] = 1; rq_ra[3] = 12'd102;
    run_batch(0, '0, '0);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rstmid_count: got %0d events expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].c !== exp_q[i].c || got_q[i].wr !== exp_q[i].wr || got_q[i].cyc !== exp_q[i].cyc || got_q[i].data !== exp_q[i].data) begin
        failures++;
        $display("FAIL rstmid_ev%0d: got c=%0d wr=%0d cyc=%0d data=%h expected c=%0d wr=%0d cyc=%0d data=%h", i,
                 got_q[i].c, got_q[i].wr, got_q[i].cyc, got_q[i].data, exp_q[i].c, exp_q[i].wr, exp_q[i].cyc, exp_q[i].data);
      end
    end
  endtask

  task automatic test_bounds();
    do_reset();
    host_wr(12'h000, 16'h7FFF);
    host_wr(12'h405, 16'hBEEF);
    checks++;
    if (oob_error !== 1'b0) begin failures++; $display("FAIL oob_host_no_flag: got %b expected 0", oob_error); end
    exp_q.delete(); got_q.delete();
    clear_req(); rq_rd[0] = 1; rq_ra[0] = 12'h400;
    run_batch(0, '0, '0);
    clear_req(); rq_wr[1] = 1; rq_wa[1] = 12'h400; rq_wd[1] = 16'h1234;
    run_batch(0, '0, '0);
    clear_req(); rq_rd[2] = 1; rq_ra[2] = 12'h000; rq_rd[3] = 1; rq_ra[3] = 12'h005;
    run_batch(0, '0, '0);
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL oob_count: got %0d events expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].c !== exp_q[i].c || got_q[i].wr !== exp_q[i].wr || got_q[i].cyc !== exp_q[i].cyc || got_q[i].data !== exp_q[i].data) begin
        failures++;
        $display("FAIL oob_ev%0d: got c=%0d wr=%0d cyc=%0d data=%h expected c=%0d wr=%0d cyc=%0d data=%h", i,
                 got_q[i].c, got_q[i].wr, got_q[i].cyc, got_q[i].data, exp_q[i].c, exp_q[i].wr, exp_q[i].cyc, exp_q[i].data);
      end
    end
    checks++;
    if (oob_error !== oob_m) begin failures++; $display("FAIL oob_flag: got %b expected %b", oob_error, oob_m); end
    do_reset();
    checks++;
    if (oob_error !== 1'b0) begin failures++; $display("FAIL oob_cleared: got %b expected 0", oob_error); end
  endtask

  task automatic test_random();
    for (int a = 0; a < 64; a++) host_wr(AB'(a), DB'($urandom));
    exp_q.delete(); got_q.delete();
    for (int r = 0; r < 25; r++) begin
      bit any;
      any = 0;
      clear_req();
      for (int c = 0; c < NC; c++) begin
        rq_rd[c] = ($urandom_range(0, 2) != 0);
        rq_wr[c] = ($urandom_range(0, 2) == 0);
        rq_ra[c] = AB'($urandom_range(0, 63) + (($urandom_range(0, 7) == 0) ? DEPTH : 0));
        rq_wa[c] = AB'($urandom_range(0, 63) + (($urandom_range(0, 7) == 0) ? DEPTH : 0));
        rq_wd[c] = DB'($urandom);
        any |= rq_rd[c] | rq_wr[c];
      end
      if (!any) rq_rd[$urandom_range(0, NC - 1)] = 1;
      run_batch(0, '0, '0);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d events expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].c !== exp_q[i].c || got_q[i].wr !== exp_q[i].wr || got_q[i].cyc !== exp_q[i].cyc || got_q[i].data !== exp_q[i].data) begin
        failures++;
        $display("FAIL rand_ev%0d: got c=%0d wr=%0d cyc=%0d data=%h expected c=%0d wr=%0d cyc=%0d data=%h", i,
                 got_q[i].c, got_q[i].wr, got_q[i].cyc, got_q[i].data, exp_q[i].c, exp_q[i].wr, exp_q[i].cyc, exp_q[i].data);
      end
    end
    checks++;
    if (oob_error !== oob_m) begin failures++; $display("FAIL rand_oob_flag: got %b expected %b", oob_error, oob_m); end
  endtask

  initial begin
    bus.read_valid  = '0;
    bus.write_valid = '0;
    for (int c = 0; c < NC; c++) begin
      bus.read_address[c] = '0; bus.write_address[c] = '0; bus.write_data[c] = '0;
    end
    clear_req();
    test_reset();
    test_single_read();
    test_arbitration();
    test_host_collision();
    test_reset_mid();
    test_bounds();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
